dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 140 ++++++++++++++
 tb/tb_dm_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares one synchronous data memory between the CPU and a
// debug port. The CPU has priority. A waiting debug request forces a single
// CPU stall cycle once it has waited MAX_WAIT consecutive busy cycles.
module dm_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_RD,
    input  logic        CPU_WR,
    input  logic [10:0] CPU_ADDR,
    input  logic [15:0] CPU_WDATA,
    output logic [15:0] CPU_RDATA,
    output logic        CPU_STALL,
    input  logic        DBG_REQ,
    input  logic        DBG_WE,
    input  logic [10:0] DBG_ADDR,
    input  logic [15:0] DBG_WDATA,
    output logic        DBG_ACK,
    output logic [15:0] DBG_RDATA,
    output logic [10:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic [15:0] MEM_DIN,
    input  logic [15:0] MEM_DOUT
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        STALL = 3'd2,
        READ  = 3'd3,
        ACK   = 3'd4
    } state_e;

    typedef struct packed {
        logic        we;
        logic [10:0] addr;
        logic [15:0] wdata;
    } dbg_req_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    dbg_req_t         req_q, req_d;
    logic [15:0]      dbg_rdata_q, dbg_rdata_d;
    logic             cpu_stall_q, cpu_stall_d;
    logic             dbg_ack_q, dbg_ack_d;
    logic             cpu_act_c;
    logic             grant_c;

    // State and registered outputs; reset drops any request in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            req_q       <= '0;
            dbg_rdata_q <= '0;
            cpu_stall_q <= 1'b0;
            dbg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_q       <= req_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_stall_q <= cpu_stall_d;
            dbg_ack_q   <= dbg_ack_d;
        end
    end

    // Next-state logic; grant_c marks the cycle the debug access owns memory.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_d       = req_q;
        dbg_rdata_d = dbg_rdata_q;
        grant_c     = 1'b0;
        cpu_act_c   = CPU_RD | CPU_WR;

        case (state_q)
            IDLE: begin
                if (DBG_REQ) begin
                    req_d      = '{we: DBG_WE, addr: DBG_ADDR, wdata: DBG_WDATA};
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (!cpu_act_c) begin
                    grant_c = 1'b1;
                    state_d = READ;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = STALL;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            STALL: begin
                grant_c = 1'b1;
                state_d = READ;
            end
            READ: begin
                // Memory returns the granted read data this cycle.
                if (!req_q.we) begin
                    dbg_rdata_d = MEM_DOUT;
                end
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_stall_d = (state_d == STALL);
        dbg_ack_d   = (state_d == ACK);
    end

    // Memory port mux: debug only on the grant cycle, CPU pass-through otherwise.
    always_comb begin
        if (grant_c) begin
            MEM_ADDR = req_q.addr;
            MEM_DIN  = req_q.wdata;
            MEM_WE   = req_q.we;
        end else begin
            MEM_ADDR = CPU_ADDR;
            MEM_DIN  = CPU_WDATA;
            MEM_WE   = CPU_WR;
        end
    end

    assign CPU_RDATA = MEM_DOUT;
    assign CPU_STALL = cpu_stall_q;
    assign DBG_ACK   = dbg_ack_q;
    assign DBG_RDATA = dbg_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a synchronous memory, a CPU that repeats a stalled
// access, and a request-level reference model (request age and grant age).
module tb_dm_arbiter;

    localparam int unsigned MW = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CPU_RD, CPU_WR;
    logic [10:0] CPU_ADDR;
    logic [15:0] CPU_WDATA, CPU_RDATA;
    logic        CPU_STALL;
    logic        DBG_REQ, DBG_WE;
    logic [10:0] DBG_ADDR;
    logic [15:0] DBG_WDATA, DBG_RDATA;
    logic        DBG_ACK;
    logic [10:0] MEM_ADDR;
    logic        MEM_WE;
    logic [15:0] MEM_DIN, MEM_DOUT;

    always #5 CLK = ~CLK;

    dm_arbiter #(.MAX_WAIT(MW)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_RD(CPU_RD), .CPU_WR(CPU_WR), .CPU_ADDR(CPU_ADDR),
        .CPU_WDATA(CPU_WDATA), .CPU_RDATA(CPU_RDATA), .CPU_STALL(CPU_STALL),
        .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR),
        .DBG_WDATA(DBG_WDATA), .DBG_ACK(DBG_ACK), .DBG_RDATA(DBG_RDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT)
    );

    // Synchronous data memory, cleared on the first clock edge.
    logic [15:0] mem [0:2047];
    bit          mem_init = 1'b0;
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= '0;
            mem_init <= 1'b1;
        end else begin
            if (MEM_WE) mem[MEM_ADDR] <= MEM_DIN;
            MEM_DOUT <= mem[MEM_ADDR];
        end
    end

    // Stimulus requested by the sequences.
    logic        s_rst, s_rd, s_wr, s_dreq, s_dwe;
    logic [10:0] s_caddr, s_daddr;
    logic [15:0] s_cwd, s_dwd;
    // Last CPU access, replayed after a stall.
    logic        p_rd, p_wr;
    logic [10:0] p_caddr;
    logic [15:0] p_cwd;
    logic        prev_stall;

    // Reference model: request phase tracked by age since the sampling edge.
    logic [15:0] gold [0:2047];
    bit          m_active, m_granted, m_we, m_ack_now;
    int          m_age, m_gage;
    logic [10:0] m_addr;
    logic [15:0] m_wdata, m_rdata, m_read_val;

    int          cyc, n_checks, n_pass, n_fail;
    bit          ack_seen;
    int          obs_ack_cyc, obs_stall_cnt;
    logic [15:0] obs_ack_rdata;
    logic [10:0] obs_stall_addr;
    logic        obs_stall_we;
    int          ack_cycs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_active   = 1'b0;
        m_granted  = 1'b0;
        m_rdata    = '0;
        prev_stall = 1'b0;
        m_ack_now  = 1'b0;
    endtask

    task automatic cpu_idle();
        s_rd = 1'b0;
        s_wr = 1'b0;
    endtask

    // One clock: drive at negedge, check 1 time unit later, advance model.
    task automatic cycle();
        logic        grant, e_stall, e_ack, e_we;
        logic [10:0] e_addr;
        logic [15:0] e_din;
        @(negedge CLK);
        RESET = s_rst;
        if (!prev_stall) begin
            p_rd = s_rd; p_wr = s_wr; p_caddr = s_caddr; p_cwd = s_cwd;
        end
        CPU_RD = p_rd; CPU_WR = p_wr; CPU_ADDR = p_caddr; CPU_WDATA = p_cwd;
        DBG_REQ = s_dreq; DBG_WE = s_dwe; DBG_ADDR = s_daddr; DBG_WDATA = s_dwd;
        #1;
        if (!RESET) model_clear();
        grant = 1'b0; e_stall = 1'b0; e_ack = 1'b0;
        if (m_active) begin
            if (!m_granted) begin
                if (m_age == int'(MW) + 1) begin
                    e_stall = 1'b1;
                    grant   = 1'b1;
                end else if (!(CPU_RD || CPU_WR)) begin
                    grant = 1'b1;
                end
            end else if (m_age == m_gage + 2) begin
                e_ack = 1'b1;
            end
        end
        e_addr = grant ? m_addr  : CPU_ADDR;
        e_din  = grant ? m_wdata : CPU_WDATA;
        e_we   = grant ? m_we    : CPU_WR;

        chk("mem_addr",  32'(MEM_ADDR),  32'(e_addr));
        chk("mem_we",    32'(MEM_WE),    32'(e_we));
        chk("mem_din",   32'(MEM_DIN),   32'(e_din));
        chk("cpu_stall", 32'(CPU_STALL), 32'(e_stall));
        chk("dbg_ack",   32'(DBG_ACK),   32'(e_ack));
        chk("dbg_rdata", 32'(DBG_RDATA), 32'(m_rdata));
        chk("cpu_rdata", 32'(CPU_RDATA), 32'(MEM_DOUT));

        if (DBG_ACK) begin
            ack_seen      = 1'b1;
            obs_ack_cyc   = cyc;
            obs_ack_rdata = DBG_RDATA;
            ack_cycs.push_back(cyc);
        end
        if (CPU_STALL) begin
            obs_stall_cnt++;
            obs_stall_addr = MEM_ADDR;
            obs_stall_we   = MEM_WE;
        end

        if (e_we) gold[e_addr] = e_din;
        if (RESET) begin
            if (!m_active) begin
                if (DBG_REQ) begin
                    m_active = 1'b1; m_granted = 1'b0; m_age = 1;
                    m_we = DBG_WE; m_addr = DBG_ADDR; m_wdata = DBG_WDATA;
                end
            end else if (e_ack) begin
                m_active = 1'b0;
            end else begin
                if (grant) begin
                    m_granted = 1'b1;
                    m_gage    = m_age;
                    m_read_val = gold[m_addr];
                end else if (m_granted && m_age == m_gage + 1 && !m_we) begin
                    m_rdata = m_read_val;
                end
                m_age++;
            end
        end
        prev_stall = e_stall;
        m_ack_now  = e_ack;
        cyc++;
        @(posedge CLK);
    endtask

    task automatic cpu_write(input logic [10:0] a, input logic [15:0] d);
        s_wr = 1'b1; s_caddr = a; s_cwd = d;
        cycle();
        cpu_idle();
    endtask

    // Full debug transaction; CPU reads for the first `busy` cycles after sampling.
    task automatic dbg_op(input logic we, input logic [10:0] a, input logic [15:0] wd,
                          input int busy, input string nm, output int age);
        int n = 0;
        int st;
        s_dreq = 1'b1; s_dwe = we; s_daddr = a; s_dwd = wd;
        cpu_idle();
        ack_seen = 1'b0; obs_stall_cnt = 0;
        st = cyc;
        cycle();
        while (!ack_seen && n < 40) begin
            if (n < busy) begin s_rd = 1'b1; s_caddr = 11'h03F; end
            else s_rd = 1'b0;
            cycle();
            n++;
        end
        chk({nm, "_ack_seen"}, 32'(ack_seen), 32'd1);
        age = obs_ack_cyc - st;
        s_dreq = 1'b0;
        cpu_idle();
        cycle();
    endtask

    initial begin
        int age;
        int st;
        n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
        obs_ack_cyc = 0; obs_stall_cnt = 0; ack_seen = 1'b0;
        for (int i = 0; i < 2048; i++) gold[i] = '0;
        model_clear();
        s_rst = 1'b0; s_dreq = 1'b0; s_dwe = 1'b0; s_daddr = '0; s_dwd = '0;
        s_rd = 1'b0; s_wr = 1'b0; s_caddr = '0; s_cwd = '0;
        p_rd = 1'b0; p_wr = 1'b0; p_caddr = '0; p_cwd = '0;
        RESET = 1'b0; CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
        DBG_REQ = 1'b0; DBG_WE = 1'b0; DBG_ADDR = '0; DBG_WDATA = '0;

        // Reset state
        repeat (3) cycle();
        chk("rst_ack",   32'(DBG_ACK),   32'd0);
        chk("rst_stall", 32'(CPU_STALL), 32'd0);
        chk("rst_rdata", 32'(DBG_RDATA), 32'd0);
        s_rst = 1'b1;
        cycle();

        // CPU idle debug read
        cpu_write(11'h005, 16'h1234);
        dbg_op(1'b0, 11'h005, 16'h0000, 0, "r036", age);
        chk("r036_latency", 32'(age), 32'd3);
        chk("r036_rdata", 32'(obs_ack_rdata), 32'h1234);
        chk("r036_stalls", 32'(obs_stall_cnt), 32'd0);

        // CPU continuously busy: forced stall, write on the stall cycle
        dbg_op(1'b1, 11'h010, 16'hBEEF, 100, "w037", age);
        chk("w037_latency", 32'(age), 32'd7);
        chk("w037_stalls", 32'(obs_stall_cnt), 32'd1);
        chk("w037_stall_addr", 32'(obs_stall_addr), 32'h010);
        chk("w037_stall_we", 32'(obs_stall_we), 32'd1);
        dbg_op(1'b0, 11'h010, 16'h0000, 0, "r037", age);
        chk("r037_rdata", 32'(obs_ack_rdata), 32'hBEEF);

        // CPU busy two cycles then idle
        dbg_op(1'b1, 11'h011, 16'h7777, 2, "w039", age);
        chk("w039_latency", 32'(age), 32'd5);
        chk("w039_stalls", 32'(obs_stall_cnt), 32'd0);

        // CPU write coincides with the stall cycle and is replayed next cycle
        s_dreq = 1'b1; s_dwe = 1'b1; s_daddr = 11'h012; s_dwd = 16'h0123;
        cpu_idle(); ack_seen = 1'b0; obs_stall_cnt = 0;
        cycle();
        s_rd = 1'b1; s_caddr = 11'h03F;
        repeat (MW) cycle();
        s_rd = 1'b0; s_wr = 1'b1; s_caddr = 11'h020; s_cwd = 16'h5A5A;
        cycle();
        #1;
        chk("s038_stalled", 32'(obs_stall_cnt), 32'd1);
        chk("s038_mem_held", 32'(mem[11'h020]), 32'h0000);
        cpu_idle();
        cycle();
        #1;
        chk("s038_mem_replay", 32'(mem[11'h020]), 32'h5A5A);
        for (int n = 0; n < 10 && !ack_seen; n++) cycle();
        chk("s038_ack_seen", 32'(ack_seen), 32'd1);
        s_dreq = 1'b0;
        cycle();
        dbg_op(1'b0, 11'h012, 16'h0000, 0, "r038a", age);
        chk("r038a_rdata", 32'(obs_ack_rdata), 32'h0123);
        dbg_op(1'b0, 11'h020, 16'h0000, 0, "r038b", age);
        chk("r038b_rdata", 32'(obs_ack_rdata), 32'h5A5A);

        // Reset asserted while the request waits
        s_dreq = 1'b1; s_dwe = 1'b1; s_daddr = 11'h030; s_dwd = 16'hDEAD;
        ack_seen = 1'b0;
        cycle();
        s_rd = 1'b1; s_caddr = 11'h03F;
        repeat (2) cycle();
        @(negedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        model_clear();
        chk("r040_ack",   32'(DBG_ACK),   32'd0);
        chk("r040_stall", 32'(CPU_STALL), 32'd0);
        chk("r040_rdata", 32'(DBG_RDATA), 32'd0);
        chk("r040_mem_we", 32'(MEM_WE),   32'd0);
        s_rst = 1'b0; s_dreq = 1'b0;
        cycle();
        s_rst = 1'b1; cpu_idle();
        repeat (8) cycle();
        chk("r040_no_ack", 32'(ack_seen), 32'd0);
        dbg_op(1'b0, 11'h030, 16'h0000, 0, "r040", age);
        chk("r040_latency", 32'(age), 32'd3);
        chk("r040_rdata_after", 32'(obs_ack_rdata), 32'h0000);

        // Request held high through ACK: next sample is after the ACK cycle
        ack_cycs.delete();
        s_dreq = 1'b1; s_dwe = 1'b0; s_daddr = 11'h005; cpu_idle();
        st = cyc;
        repeat (9) cycle();
        s_dreq = 1'b0;
        repeat (6) cycle();
        chk("b041_acks", 32'(ack_cycs.size()), 32'd3);
        if (ack_cycs.size() >= 2) begin
            chk("b041_first", 32'(ack_cycs[0] - st), 32'd3);
            chk("b041_gap", 32'(ack_cycs[1] - ack_cycs[0]), 32'd4);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 4)
                0: begin s_rd = 1'b1; s_wr = 1'b0; end
                1: begin s_rd = 1'b0; s_wr = 1'b1; end
                default: cpu_idle();
            endcase
            s_caddr = 11'($urandom % 64);
            s_cwd   = 16'($urandom);
            if (!s_dreq && !m_active && ($urandom % 4) == 0) begin
                s_dreq = 1'b1; s_dwe = 1'($urandom % 2);
                s_daddr = 11'($urandom % 64); s_dwd = 16'($urandom);
            end else if (s_dreq && m_active && !m_ack_now && ($urandom % 8) == 0) begin
                s_dreq = 1'b0;
            end
            cycle();
            if (m_ack_now && ($urandom % 3) != 0) s_dreq = 1'b0;
        end
        s_dreq = 1'b0; cpu_idle();
        repeat (12) cycle();
        #1;
        for (int a = 0; a < 64; a++) chk("mem_final", 32'(mem[a]), 32'(gold[a]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
